// File: rtl/approx_sad_accum.sv
// approx_sad_accum: streaming approximate SAD engine, one sum per frame on a valid/ready port.
// Define APPROX_SUB_EXACT_EN to use the exact 16-bit |a-b| as a golden reference.
module approx_sad_accum #(
  parameter int ACC_W     = 24,
  parameter int CNT_W     = 12,
  parameter int FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_a,
  input  logic [15:0]      s_b,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_sum,
  output logic [CNT_W-1:0] m_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
  state_t state_q, state_d;
  logic rdy_q, v1_q, take, close, clr;
  logic [15:0] d, d_q;
  logic [1:0] dr_q, dr_d;
  logic [CNT_W-1:0] in_q, in_d, cnt_q;
  logic [ACC_W-1:0] acc_q;
`ifdef APPROX_SUB_EXACT_EN
  assign d = (s_a >= s_b) ? s_a - s_b : s_b - s_a;
`else
  assign d[15:8] = (s_a[15:8] >= s_b[15:8]) ? s_a[15:8] - s_b[15:8] : s_b[15:8] - s_a[15:8];
  assign d[7:4]  = s_a[7:4] & ~s_b[7:4];
  assign d[3:2]  = s_a[3:2] ^ s_b[3:2];
  assign d[1:0]  = 2'b00;
`endif
  // rdy_q keeps s_ready low until the first edge after reset release
  assign s_ready = rdy_q && (state_q == IDLE || state_q == ACCUM);
  assign take    = s_valid && s_ready;
  assign close   = take && (s_last || in_q == CNT_W'(FRAME_LEN - 1));
  assign m_valid = state_q == HOLD;
  assign clr     = m_valid && m_ready;
  assign m_sum   = acc_q;
  assign m_count = cnt_q;
  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    in_d    = in_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (take) begin
          in_d    = in_q + 1'b1;
          dr_d    = 2'd0;
          state_d = close ? DRAIN : ACCUM;
        end
      end
      DRAIN: begin
        dr_d    = dr_q + 1'b1;
        state_d = (dr_q == 2'd2) ? HOLD : DRAIN;
      end
      HOLD: begin
        state_d = m_ready ? IDLE : HOLD;
        in_d    = m_ready ? '0 : in_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      dr_q    <= '0;
      in_q    <= '0;
      v1_q    <= 1'b0;
      d_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      dr_q    <= dr_d;
      in_q    <= in_d;
      v1_q    <= take;
      if (take) d_q <= d;
      if (clr) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (v1_q) begin
        acc_q <= acc_q + ACC_W'(d_q);
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule
